// File: rtl/mul_sequencer.sv
// mul_sequencer: queues operand pairs and feeds them one at a time to a multi-cycle multiplier.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   op_a, op_b, op_vld  upstream operand pair and its valid; op_rdy says the queue has room
//   mul_a, mul_b        operands to the multiplier, loaded by the one-cycle mul_vld strobe
//   mul_res, mul_res_rdy multiplier product and its idle/done level
//   out_res, out_vld    registered product, held until out_rdy accepts it
//   err                 sticky timeout flag (only active when MUL_SEQ_TIMEOUT_EN is defined)
// Build option: define MUL_SEQ_TIMEOUT_EN to abandon a multiplier that stays busy too long.
module mul_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  op_a,
    input  logic [7:0]  op_b,
    input  logic        op_vld,
    output logic        op_rdy,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    output logic        mul_vld,
    input  logic [15:0] mul_res,
    input  logic        mul_res_rdy,
    output logic [15:0] out_res,
    output logic        out_vld,
    input  logic        out_rdy,
    output logic        err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t        state;
    logic [7:0]    fa [DEPTH];
    logic [7:0]    fb [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop, cap;

    assign op_rdy = count < (AW+1)'(DEPTH);
    assign push   = op_vld && op_rdy;
    // the head is read out and popped on the edge that enters ISSUE
    assign pop    = state == IDLE && count != '0;
    assign cap    = state == WAIT && mul_res_rdy && (!out_vld || out_rdy);

    always_ff @(posedge clk) begin
        if (push) begin
            fa[wr_ptr] <= op_a;
            fb[wr_ptr] <= op_b;
        end
    end

`ifdef MUL_SEQ_TIMEOUT_EN
    logic [3:0] tcnt;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            mul_vld <= 1'b0;
            mul_a   <= '0;
            mul_b   <= '0;
            out_vld <= 1'b0;
            out_res <= '0;
`ifdef MUL_SEQ_TIMEOUT_EN
            err     <= 1'b0;
            tcnt    <= '0;
`endif
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (cap) begin
                out_res <= mul_res;
                out_vld <= 1'b1;
            end else if (out_rdy) begin
                out_vld <= 1'b0;
            end
            mul_vld <= 1'b0;
            mul_a   <= '0;
            mul_b   <= '0;
            case (state)
                IDLE: if (pop) begin
                    state   <= ISSUE;
                    mul_vld <= 1'b1;
                    mul_a   <= fa[rd_ptr];
                    mul_b   <= fb[rd_ptr];
                end
                ISSUE: begin
                    state <= WAIT;
`ifdef MUL_SEQ_TIMEOUT_EN
                    tcnt  <= '0;
`endif
                end
                WAIT: begin
                    if (cap)
                        state <= IDLE;
`ifdef MUL_SEQ_TIMEOUT_EN
                    // the 15th busy WAIT cycle brings the counter to 15: give up on this operation
                    else if (!mul_res_rdy) begin
                        tcnt <= tcnt + 4'd1;
                        if (tcnt == 4'd14) begin
                            err   <= 1'b1;
                            state <= IDLE;
                        end
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: directed and random checks of mul_sequencer against an in-order product queue.
module tb_mul_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  op_a = '0, op_b = '0;
    logic        op_vld = 1'b0, op_rdy;
    logic [7:0]  mul_a, mul_b;
    logic        mul_vld;
    logic [15:0] mul_res;
    logic        mul_res_rdy;
    logic [15:0] out_res;
    logic        out_vld;
    logic        out_rdy = 1'b0;
    logic        err;

    int          n_vec = 0, n_err = 0, n_out = 0;
    logic [15:0] q[$];
    bit          stuck = 1'b0;
    logic [3:0]  mcnt;
    logic [15:0] mres;

    always #5 clk = ~clk;

    mul_sequencer #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .op_a(op_a), .op_b(op_b), .op_vld(op_vld), .op_rdy(op_rdy),
        .mul_a(mul_a), .mul_b(mul_b), .mul_vld(mul_vld),
        .mul_res(mul_res), .mul_res_rdy(mul_res_rdy),
        .out_res(out_res), .out_vld(out_vld), .out_rdy(out_rdy),
        .err(err)
    );

    // multiplier model: busy for 8 edges after a load, result held afterwards
    always @(posedge clk) begin
        if (rst) begin
            mcnt <= '0;
            mres <= '0;
        end else if (mul_vld) begin
            mcnt <= 4'd8;
            mres <= 16'(mul_a) * 16'(mul_b);
        end else if (mcnt != 0) begin
            mcnt <= mcnt - 4'd1;
        end
    end
    assign mul_res     = mres;
    assign mul_res_rdy = !stuck && mcnt == 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one clock: scoreboard accepts and drains seen at the edge, then settle 1 time unit
    task automatic tick();
        bit acc, drn;
        logic [15:0] p, r;
        acc = !rst && op_vld && op_rdy;
        drn = !rst && out_vld && out_rdy;
        p = 16'(op_a) * 16'(op_b);
        r = out_res;
        @(posedge clk);
        #1;
        if (rst) q.delete();
        else begin
            if (drn) begin
                n_out++;
                chk("sb_nonempty", q.size() != 0, 1);
                if (q.size() != 0) chk("order", r, q.pop_front());
            end
            if (acc) q.push_back(p);
        end
    endtask

    task automatic push_op(input logic [7:0] a, input logic [7:0] b);
        int t;
        op_a = a; op_b = b; op_vld = 1'b1; t = 0;
        while (!op_rdy && t < 200) begin tick(); t++; end
        chk("push_bound", t < 200, 1);
        tick();
        op_vld = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        int t;
        t = 0;
        while (q.size() != 0 && t < bound) begin tick(); t++; end
        chk("drain_bound", q.size(), 0);
    endtask

    task automatic run_one(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
        int t;
        out_rdy = 1'b1;
        push_op(a, b);
        t = 0;
        while (!out_vld && t < 60) begin tick(); t++; end
        chk("run_one_res", out_res, exp);
        wait_drain(60);
    endtask

    function automatic logic [7:0] pick();
        int s;
        s = $urandom_range(0, 5);
        return s == 0 ? 8'h00 : s == 1 ? 8'hFF : 8'($urandom);
    endfunction

    initial begin
        int k, first_low, n0, stale;
        tick(); tick();
        chk("rst_op_rdy", op_rdy, 1);
        chk("rst_mul_vld", mul_vld, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_mul_b", mul_b, 0);
        chk("rst_out_vld", out_vld, 0);
        chk("rst_out_res", out_res, 16'h0000);
        chk("rst_err", err, 0);
        rst = 1'b0;
        tick();

        // latency: accept at edge 0
        out_rdy = 1'b1;
        op_a = 8'd3; op_b = 8'd5; op_vld = 1'b1;
        tick();
        op_vld = 1'b0;
        chk("lat_e0_mul_vld", mul_vld, 0);
        tick();
        chk("lat_e1_mul_vld", mul_vld, 1);
        chk("lat_e1_mul_a", mul_a, 3);
        chk("lat_e1_mul_b", mul_b, 5);
        tick();
        chk("lat_e2_mul_vld", mul_vld, 0);
        chk("lat_e2_mul_a", mul_a, 0);
        for (int e = 3; e <= 10; e++) begin
            tick();
            chk("lat_early_out_vld", out_vld, 0);
        end
        tick();
        chk("lat_e11_out_vld", out_vld, 1);
        chk("lat_e11_out_res", out_res, 16'h000F);
        tick();
        chk("lat_e12_out_vld", out_vld, 0);
        chk("lat_drained", n_out, 1);

        run_one(8'd255, 8'd255, 16'hFE01);
        run_one(8'd0, 8'd200, 16'h0000);

        // random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            op_vld  = $urandom_range(0, 1) == 1;
            op_a    = pick();
            op_b    = pick();
            out_rdy = $urandom_range(0, 3) != 0;
            tick();
        end
        op_vld = 1'b0; out_rdy = 1'b1;
        wait_drain(600);

        // fill with the consumer stalled
        out_rdy = 1'b0;
        n0 = n_out; k = 0; first_low = -1;
        op_vld = 1'b1; op_a = 8'd1; op_b = 8'd10;
        for (int t = 0; t < 200 && k < 6; t++) begin
            if (op_rdy) begin
                tick();
                k++;
                op_a = 8'(k * 17 + 1); op_b = 8'(k + 10);
            end else begin
                if (first_low < 0) first_low = k;
                tick();
            end
        end
        op_vld = 1'b0;
        chk("full_at_accepts", first_low, 5);
        chk("all_accepted", k, 6);
        for (int t = 0; t < 20; t++) tick();
        chk("hold_out_vld", out_vld, 1);
        chk("hold_out_res", out_res, 16'(8'd1) * 16'(8'd10));
        out_rdy = 1'b1;
        wait_drain(400);
        chk("fill_drained", n_out - n0, 6);

        // reset while waiting with two operands queued
        op_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            op_a = 8'(i + 2); op_b = 8'(i + 7);
            tick();
        end
        op_vld = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstw_out_vld", out_vld, 0);
        chk("rstw_op_rdy", op_rdy, 1);
        chk("rstw_mul_vld", mul_vld, 0);
        stale = 0;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (out_vld || mul_vld) stale++;
        end
        chk("rstw_no_stale", stale, 0);

`ifdef MUL_SEQ_TIMEOUT_EN
        stuck = 1'b1;
        op_a = 8'd4; op_b = 8'd4; op_vld = 1'b1;
        tick();
        op_vld = 1'b0;
        for (int e = 1; e <= 16; e++) tick();
        chk("to_err_before", err, 0);
        tick();
        chk("to_err_set", err, 1);
        chk("to_out_vld", out_vld, 0);
        if (q.size() != 0) void'(q.pop_front());
        stuck = 1'b0;
        run_one(8'd7, 8'd9, 16'h003F);
        chk("to_err_sticky", err, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("to_err_cleared", err, 0);
`else
        stuck = 1'b1;
        push_op(8'd7, 8'd9);
        for (int t = 0; t < 40; t++) tick();
        chk("nto_err", err, 0);
        chk("nto_out_vld", out_vld, 0);
        stuck = 1'b0;
        k = 0;
        while (!out_vld && k < 30) begin tick(); k++; end
        chk("nto_res", out_res, 16'h003F);
        wait_drain(30);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
